posit_decode_pipe: RTL and testbench

Two-stage pipelined posit decoder sitting directly upstream of the posit multiplier datapath. It accepts one 32-bit, es=4 posit word per cycle over a valid/ready handshake. It emits the decoded fields in the exact form the multiplier consumes: sign, regime value k, regime length, 4-bit exponent, and 27-bit MSB-aligned fraction. Zero and NaR flags are broken out, so the multiply stage is reduced to field arithmetic and packing.

---
 rtl/posit_pkg.sv | 34 +++
 rtl/posit_run_counter.sv | 30 +++
 rtl/posit_decode_pipe.sv | 107 ++++++++++
 tb/tb_posit_decode_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit constants and the decoded-field record handed to the multiplier.
package posit_pkg;

  localparam int unsigned N  = 32;
  localparam int unsigned ES = 4;
  localparam int unsigned FW = 27;
  localparam int unsigned MW = N - 1;  // magnitude field, bits 30:0
  localparam int unsigned KW = 6;      // signed regime value, -30..30
  localparam int unsigned LW = 5;      // regime length, 2..31
  localparam int unsigned RW = 5;      // raw run length, 1..31

  localparam logic [N-1:0] POSIT_NAR = 32'h8000_0000;

  typedef struct packed {
    logic          sign;
    logic [KW-1:0] k;
    logic [LW-1:0] len;
    logic [ES-1:0] exp;
    logic [FW-1:0] frac;
    logic          zero;
    logic          nar;
  } posit_dec_t;

  // Regime length includes the terminator bit, capped at the magnitude width.
  function automatic logic [LW-1:0] regime_len(input logic [RW-1:0] run);
    logic [RW:0] run_p1;
    run_p1 = {1'b0, run} + (RW+1)'(1);
    if (run_p1 > (RW+1)'(MW)) begin
      return LW'(MW);
    end
    return run_p1[LW-1:0];
  endfunction

endpackage

// File: rtl/posit_run_counter.sv
// Leading identical-bit run detector over the posit magnitude field.
module posit_run_counter
  import posit_pkg::*;
(
  input  logic [MW-1:0] mag,
  output logic [RW-1:0] run,
  output logic          polarity
);

  logic [MW-1:0] norm;
  logic          found;

  // Fold a run of ones into a run of zeros, then count leading zeros.
  always_comb begin
    polarity = mag[MW-1];
    norm     = polarity ? ~mag : mag;
    run      = '0;
    found    = 1'b0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (!found) begin
        if (norm[i]) begin
          found = 1'b1;
        end else begin
          run = run + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit (N=32, es=4) field decoder with valid/ready flow control.
module posit_decode_pipe
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [KW-1:0] out_k,
  output logic [LW-1:0] out_len,
  output logic [ES-1:0] out_exp,
  output logic [FW-1:0] out_frac,
  output logic          out_zero,
  output logic          out_nar
);

  logic          v1;
  logic          v2;
  logic          adv2;
  logic [N-1:0]  s1_data;
  logic [RW-1:0] s1_run;
  logic          s1_pol;
  logic          s1_zero;
  logic          s1_nar;

  logic [RW-1:0] run_c;
  logic          pol_c;
  logic [LW-1:0] len_c;
  logic [MW-1:0] shifted_c;
  posit_dec_t    dec_c;
  posit_dec_t    dec_q;

  posit_run_counter u_run (
    .mag      (in_data[MW-1:0]),
    .run      (run_c),
    .polarity (pol_c)
  );

  // A stage advances when its successor is empty or draining.
  assign adv2     = !v2 || out_ready;
  assign in_ready = !v1 || adv2;

  // Stage 1: capture the word, its regime run and the special-value flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      s1_data <= '0;
      s1_run  <= '0;
      s1_pol  <= 1'b0;
      s1_zero <= 1'b0;
      s1_nar  <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_run  <= run_c;
        s1_pol  <= pol_c;
        s1_zero <= (in_data == '0);
        s1_nar  <= (in_data == POSIT_NAR);
      end
    end
  end

  // Shifting past the regime leaves exponent then fraction MSB-aligned,
  // with truncated bits naturally filled by zeros.
  always_comb begin
    dec_c     = '0;
    len_c     = regime_len(s1_run);
    shifted_c = s1_data[MW-1:0] << len_c;
    dec_c.sign = s1_data[N-1];
    dec_c.zero = s1_zero;
    dec_c.nar  = s1_nar;
    if (!(s1_zero || s1_nar)) begin
      dec_c.k    = s1_pol ? (KW'(s1_run) - KW'(1)) : -KW'(s1_run);
      dec_c.len  = len_c;
      dec_c.exp  = shifted_c[MW-1 -: ES];
      dec_c.frac = shifted_c[FW-1:0];
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      dec_q <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        dec_q <= dec_c;
      end
    end
  end

  assign out_valid = v2;
  assign out_sign  = dec_q.sign;
  assign out_k     = dec_q.k;
  assign out_len   = dec_q.len;
  assign out_exp   = dec_q.exp;
  assign out_frac  = dec_q.frac;
  assign out_zero  = dec_q.zero;
  assign out_nar   = dec_q.nar;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe: directed vectors plus a scoreboard model.
module tb_posit_decode_pipe;
  import posit_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign;
  logic [KW-1:0] out_k;
  logic [LW-1:0] out_len;
  logic [ES-1:0] out_exp;
  logic [FW-1:0] out_frac;
  logic          out_zero;
  logic          out_nar;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  posit_dec_t exp_q[$];
  posit_dec_t cur;

  posit_decode_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_k     (out_k),
    .out_len   (out_len),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_nar   (out_nar)
  );

  always #5 clk = ~clk;

  assign cur = {out_sign, out_k, out_len, out_exp, out_frac, out_zero, out_nar};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic posit_dec_t mk(input logic s, input logic [5:0] k, input logic [4:0] l,
                                    input logic [3:0] e, input logic [26:0] f,
                                    input logic z, input logic n);
    mk = {s, k, l, e, f, z, n};
  endfunction

  // Decode straight from the number format: count the regime run, drop the
  // leading len bits of the magnitude, read exponent then fraction.
  function automatic posit_dec_t model(input logic [31:0] w);
    posit_dec_t m;
    int r;
    int k;
    int len;
    longint unsigned mag;
    longint unsigned rem;
    logic [30:0] s;
    m = '0;
    m.sign = w[31];
    if (w == 32'h0) begin
      m.zero = 1'b1;
      return m;
    end
    if (w == 32'h8000_0000) begin
      m.nar = 1'b1;
      return m;
    end
    r = 0;
    while (r < 31 && w[30-r] == w[30]) r++;
    k   = w[30] ? r - 1 : -r;
    len = (r + 1 > 31) ? 31 : r + 1;
    mag = 64'(w[30:0]);
    rem = mag % (64'd1 << (31 - len));
    s   = 31'(rem << len);
    m.k    = 6'(k);
    m.len  = 5'(len);
    m.exp  = s[30:27];
    m.frac = s[26:0];
    return m;
  endfunction

  // Scoreboard: push model results on accept, pop and compare on output transfer.
  initial begin : monitor
    posit_dec_t prev;
    posit_dec_t e;
    logic prev_hold;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("hold_stable", 64'({out_valid, cur}), 64'({1'b1, prev}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %h want none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("decode", 64'(cur), 64'(e));
            n_out++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_data));
        prev_hold = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  // One word with out_ready high; fields must appear two cycles after presentation.
  task automatic send_check(input string name, input logic [31:0] word, input posit_dec_t req);
    in_valid  = 1'b1;
    in_data   = word;
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk); #1;
    chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_fields"}, 64'(cur), 64'(req));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] sw[5];
    logic [31:0] mix[10];
    int idx;
    logic acc;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_fields", 64'(cur), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    chk("model_pin_3c8", 64'(model(32'h3C80_0000)), 64'(mk(1'b0, 6'h3F, 5'd2, 4'hE, 27'h200_0000, 1'b0, 1'b0)));
    chk("model_pin_5a5", 64'(model(32'h5A5A_5A5A)), 64'(mk(1'b0, 6'd0, 5'd2, 4'hD, 27'h169_6968, 1'b0, 1'b0)));

    send_check("w40000000", 32'h4000_0000, mk(1'b0, 6'd0,  5'd2,  4'h0, 27'h0,        1'b0, 1'b0));
    send_check("w3c800000", 32'h3C80_0000, mk(1'b0, 6'h3F, 5'd2,  4'hE, 27'h200_0000, 1'b0, 1'b0));
    send_check("w7fffffff", 32'h7FFF_FFFF, mk(1'b0, 6'd30, 5'd31, 4'h0, 27'h0,        1'b0, 1'b0));
    send_check("wfffffffe", 32'hFFFF_FFFE, mk(1'b1, 6'd29, 5'd31, 4'h0, 27'h0,        1'b0, 1'b0));
    send_check("wzero",     32'h0000_0000, mk(1'b0, 6'd0,  5'd0,  4'h0, 27'h0,        1'b1, 1'b0));
    send_check("wnar",      32'h8000_0000, mk(1'b1, 6'd0,  5'd0,  4'h0, 27'h0,        1'b0, 1'b1));
    send_check("w00000001", 32'h0000_0001, mk(1'b0, 6'h22, 5'd31, 4'h0, 27'h0,        1'b0, 1'b0));
    send_check("w5a5a5a5a", 32'h5A5A_5A5A, mk(1'b0, 6'd0,  5'd2,  4'hD, 27'h169_6968, 1'b0, 1'b0));

    // Back-to-back stream of 5 with downstream stalled in cycles 3-6.
    sw = '{32'h4000_0000, 32'h3C80_0000, 32'h6000_0000, 32'hC123_4567, 32'h1C00_0000};
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid  = (idx < 5);
      in_data   = (idx < 5) ? sw[idx] : '0;
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 3) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (c >= 7 && c <= 10) chk("no_gap_out_valid", 64'(out_valid), 64'd1);
      if (c == 11) chk("stream_empty", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;

    // Mixed stream with bursty valid and ready, checked by the scoreboard.
    mix = '{32'h4000_0000, 32'h6000_0000, 32'h1C00_0000, 32'hC000_0001, 32'h0000_0001,
            32'h8000_0000, 32'h7FFF_FFFD, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (idx < 10) && (c % 4 != 2);
      in_data   = (idx < 10) ? mix[idx] : '0;
      out_ready = (c % 3 != 1);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("mix_all_sent", 64'(idx), 64'd10);
    repeat (4) @(posedge clk);
    #1;

    // Reset with two words in flight discards them.
    in_valid = 1'b1;
    in_data  = 32'h3C80_0000;
    @(posedge clk); #1;
    in_data = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_fields", 64'(cur), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    send_check("post_reset", 32'h6000_0000, mk(1'b0, 6'd1, 5'd3, 4'h0, 27'h0, 1'b0, 1'b0));

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("outputs_seen", 64'(n_out), 64'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
